// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256 schedule constants, state type and small-sigma functions.
package sha256_pkg;
  localparam int BLOCK_WORDS = 16;
  localparam int NUM_ROUNDS = 64;
  typedef enum logic {LOAD, RUN} sched_state_e;
  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction
  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction
endpackage

// File: rtl/sha256_sched_expand.sv
// sha256_sched_expand: combinational expansion producing the word shifted into win[15].
module sha256_sched_expand
  import sha256_pkg::*;
(
  input  logic [31:0] win0_i,
  input  logic [31:0] win1_i,
  input  logic [31:0] win9_i,
  input  logic [31:0] win14_i,
  output logic [31:0] win15_o
);
  assign win15_o = small_sigma1(win14_i) + win9_i + small_sigma0(win1_i) + win0_i;
endmodule

// File: rtl/sha256_msg_schedule.sv
// sha256_msg_schedule: loads a 16-word block and streams W[0..NUM_ROUNDS-1] over valid/ready.
// Define SHA256_SCHED_IDX_EN to add the w_idx round-index output.
module sha256_msg_schedule #(
  parameter int NUM_ROUNDS = sha256_pkg::NUM_ROUNDS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        w_valid,
  input  logic        w_ready,
  output logic [31:0] w_data,
  output logic        w_last
`ifdef SHA256_SCHED_IDX_EN
  ,
  output logic [5:0]  w_idx
`endif
);
  import sha256_pkg::*;
  sched_state_e state_q;
  logic [31:0] win_q [BLOCK_WORDS];
  logic [3:0]  load_cnt_q;
  logic [5:0]  round_cnt_q;
  logic [31:0] win15_d;
  sha256_sched_expand u_expand (
    .win0_i (win_q[0]),
    .win1_i (win_q[1]),
    .win9_i (win_q[9]),
    .win14_i(win_q[14]),
    .win15_o(win15_d)
  );
  assign in_ready = state_q == LOAD;
  assign w_valid  = state_q == RUN;
  assign w_data   = win_q[0];
  assign w_last   = w_valid && round_cnt_q == 6'(NUM_ROUNDS - 1);
`ifdef SHA256_SCHED_IDX_EN
  assign w_idx    = w_valid ? round_cnt_q : '0;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      load_cnt_q  <= '0;
      round_cnt_q <= '0;
      for (int i = 0; i < BLOCK_WORDS; i++) win_q[i] <= '0;
    end else if (state_q == LOAD) begin
      if (in_valid) begin
        win_q[load_cnt_q] <= in_data;
        load_cnt_q        <= load_cnt_q + 4'd1;
        if (load_cnt_q == 4'(BLOCK_WORDS - 1)) begin
          state_q     <= RUN;
          round_cnt_q <= '0;
        end
      end
    end else if (w_ready) begin
      // expansion runs on every emitted word, even t<16, so the window stays in phase
      for (int i = 0; i < BLOCK_WORDS - 1; i++) win_q[i] <= win_q[i + 1];
      win_q[BLOCK_WORDS - 1] <= win15_d;
      round_cnt_q            <= round_cnt_q + 6'd1;
      if (w_last) state_q <= LOAD;
    end
  end
endmodule
